fifo_burst_reader: RTL and testbench

//  Read-side consumer for the showahead ASYNCFIFO, in the ReadClk domain. Waits for a

---
 rtl/fifo_burst_reader.sv | 135 +++++++++++++
 tb/tb_fifo_burst_reader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Read-side burst consumer for a showahead FIFO: collects a burst (or times out),
// pops it and forwards the words on a valid/ready stream with a last marker.
module fifo_burst_reader #(
  parameter int DataWidth     = 32,
  parameter int RAMAddWidth   = 2,
  parameter int BurstLen      = 4,
  parameter int TimeoutCycles = 16
) (
  input  logic                   ReadClk,
  input  logic                   ReadReset,
  input  logic [DataWidth-1:0]   FifoReadData,
  input  logic                   FifoNotEmpty,
  input  logic [RAMAddWidth-1:0] FifoRdusedw,
  output logic                   FifoRead,
  output logic [DataWidth-1:0]   OutData,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic                   OutLast,
  input  logic                   Flush,
  output logic                   Busy,
  output logic [15:0]            BurstCount
);

  localparam int BW = RAMAddWidth + 1;
  localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]           state;
  logic [TW-1:0]        timer;
  logic [BW-1:0]        beats;
  logic [BW-1:0]        used;
  logic [15:0]          burst_count;

  logic [DataWidth-1:0] buf_data [2];
  logic [1:0]           buf_last;
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [1:0]           buf_count;
  logic                 push;
  logic                 pop;

  // A zero used-count on a non-empty FIFO means the count has wrapped at full depth.
  assign used = (FifoRdusedw == '0 && FifoNotEmpty) ? {1'b1, {RAMAddWidth{1'b0}}}
                                                     : {1'b0, FifoRdusedw};

  // Pop depends only on registered buffer state, never on OutReady.
  assign FifoRead = (state == S_BURST) & FifoNotEmpty & ~buf_count[1] &
                    (beats != '0) & ~Flush & ~ReadReset;

  assign push       = FifoRead;
  assign pop        = (buf_count != '0) & OutReady;
  assign OutValid   = (buf_count != '0);
  assign OutData    = OutValid ? buf_data[rd_ptr] : '0;
  assign OutLast    = OutValid & buf_last[rd_ptr];
  assign Busy       = (state != S_IDLE);
  assign BurstCount = burst_count;

  always_ff @(posedge ReadClk) begin
    if (ReadReset) begin
      state       <= S_IDLE;
      timer       <= '0;
      beats       <= '0;
      burst_count <= '0;
    end else if (Flush) begin
      state <= S_IDLE;
      beats <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (FifoNotEmpty) begin
            state <= S_WAIT;
            timer <= '0;
          end
        end
        S_WAIT: begin
          if (used >= BW'(BurstLen)) begin
            state <= S_BURST;
            beats <= BW'(BurstLen);
          end else if (timer == TW'(TimeoutCycles - 1)) begin
            if (FifoNotEmpty) begin
              state <= S_BURST;
              beats <= used;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_BURST: begin
          if (FifoRead) begin
            beats <= beats - 1'b1;
            if (beats == BW'(1)) begin
              state       <= S_DRAIN;
              burst_count <= burst_count + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (buf_count == '0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ReadClk) begin
    if (ReadReset || Flush) begin
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      buf_count <= '0;
      buf_last  <= '0;
    end else begin
      if (push) begin
        buf_last[wr_ptr] <= (beats == BW'(1));
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   buf_count <= buf_count + 1'b1;
        2'b01:   buf_count <= buf_count - 1'b1;
        default: buf_count <= buf_count;
      endcase
    end
  end

  always_ff @(posedge ReadClk) begin
    if (push) buf_data[wr_ptr] <= FifoReadData;
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a small showahead FIFO model in front.
module tb_fifo_burst_reader;

  logic        ReadClk = 1'b0;
  logic        ReadReset;
  logic [31:0] FifoReadData;
  logic        FifoNotEmpty;
  logic [1:0]  FifoRdusedw;
  logic        FifoRead;
  logic [31:0] OutData;
  logic        OutValid;
  logic        OutReady;
  logic        OutLast;
  logic        Flush;
  logic        Busy;
  logic [15:0] BurstCount;

  always #5 ReadClk = ~ReadClk;

  fifo_burst_reader #(
    .DataWidth(32),
    .RAMAddWidth(2),
    .BurstLen(4),
    .TimeoutCycles(16)
  ) dut (
    .ReadClk(ReadClk),
    .ReadReset(ReadReset),
    .FifoReadData(FifoReadData),
    .FifoNotEmpty(FifoNotEmpty),
    .FifoRdusedw(FifoRdusedw),
    .FifoRead(FifoRead),
    .OutData(OutData),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .OutLast(OutLast),
    .Flush(Flush),
    .Busy(Busy),
    .BurstCount(BurstCount)
  );

  // Showahead FIFO model, depth 4; writes arrive as a batch of push_n words.
  logic [31:0] fmem [4];
  logic [1:0]  f_wr, f_rd;
  logic [2:0]  f_cnt;
  logic [31:0] push_words [4];
  int          push_n;

  assign FifoReadData = fmem[f_rd];
  assign FifoNotEmpty = (f_cnt != 3'd0);
  assign FifoRdusedw  = f_cnt[1:0];

  always @(posedge ReadClk) begin
    if (ReadReset) begin
      f_wr  <= 2'd0;
      f_rd  <= 2'd0;
      f_cnt <= 3'd0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (i < push_n) fmem[2'(f_wr + 2'(i))] <= push_words[i];
      f_wr  <= f_wr + 2'(push_n);
      f_rd  <= f_rd + (FifoRead ? 2'd1 : 2'd0);
      f_cnt <= f_cnt + 3'(push_n) - (FifoRead ? 3'd1 : 3'd0);
    end
  end

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc, pops, first_pop, last_pop, wait_cyc, nbeats;
  logic [31:0] beat_data [8];
  logic        beat_last [8];
  logic [31:0] exp_w [4];
  logic [15:0] exp_bc;
  bit          done;

  typedef struct {
    int          n;
    logic [31:0] base;
    int          exp_wait;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; pops = 0; first_pop = 0; last_pop = 0; wait_cyc = 0; nbeats = 0; done = 0;
  endtask

  // One clock: sample at negedge, then drive from 1 time unit after posedge.
  task automatic cycle();
    @(negedge ReadClk);
    if (FifoRead) begin
      if (pops == 0) first_pop = cyc;
      last_pop = cyc;
      pops++;
    end else if (Busy && pops == 0) begin
      wait_cyc++;
    end
    if (OutValid && OutReady && nbeats < 8) begin
      beat_data[nbeats] = OutData;
      beat_last[nbeats] = OutLast;
      nbeats++;
    end
    cyc++;
    @(posedge ReadClk);
    #1;
    push_n = 0;
  endtask

  task automatic load(input int n, input logic [31:0] base);
    for (int i = 0; i < 4; i++) push_words[i] = base + 32'(i);
    push_n = n;
  endtask

  task automatic run_done(input int n, input int budget);
    for (int k = 0; k < budget && !(pops >= n && !Busy); k++) cycle();
    done = (pops >= n && !Busy);
  endtask

  task automatic run_pops(input string tag, input int target, input int budget);
    for (int k = 0; k < budget && pops < target; k++) cycle();
    chk({tag, "_reached"}, 64'(pops >= target), 64'd1);
  endtask

  task automatic check_burst(input string tag, input int n, input int exp_wait, input bit chk_span);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_pops"}, 64'(pops), 64'(n));
    chk({tag, "_wait"}, 64'(wait_cyc), 64'(exp_wait));
    if (chk_span) chk({tag, "_span"}, 64'(last_pop - first_pop), 64'(n - 1));
    chk({tag, "_beats"}, 64'(nbeats), 64'(n));
    for (int i = 0; i < n && i < nbeats; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 64'(beat_data[i]), 64'(exp_w[i]));
      chk($sformatf("%s_last%0d", tag, i), 64'(beat_last[i]), 64'(i == n - 1));
    end
    exp_bc++;
    chk({tag, "_bcount"}, 64'(BurstCount), 64'(exp_bc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unstable;
    vecs[0] = '{n: 4, base: 32'h0000_00A0, exp_wait: 1};
    vecs[1] = '{n: 1, base: 32'h0000_0055, exp_wait: 16};
    vecs[2] = '{n: 2, base: 32'h0000_1000, exp_wait: 16};
    vecs[3] = '{n: 3, base: 32'hBEEF_0000, exp_wait: 16};
    vecs[4] = '{n: 4, base: 32'h0000_00C0, exp_wait: 1};

    ReadReset = 1'b1; Flush = 1'b0; OutReady = 1'b1; push_n = 0;
    for (int i = 0; i < 4; i++) push_words[i] = '0;
    exp_bc = '0;
    repeat (2) @(posedge ReadClk);
    #1;
    chk("rst_fiforead", 64'(FifoRead), 64'd0);
    chk("rst_valid", 64'(OutValid), 64'd0);
    chk("rst_last", 64'(OutLast), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_data", 64'(OutData), 64'd0);
    chk("rst_bcount", 64'(BurstCount), 64'd0);
    ReadReset = 1'b0;
    cycle();

    for (int v = 0; v < 5; v++) begin
      clear_stats();
      for (int i = 0; i < 4; i++) exp_w[i] = vecs[v].base + 32'(i);
      load(vecs[v].n, vecs[v].base);
      run_done(vecs[v].n, 80);
      check_burst($sformatf("vec%0d", v), vecs[v].n, vecs[v].exp_wait, 1'b1);
    end

    // Backpressure: only two pops fit in the buffer, outputs must hold.
    clear_stats();
    OutReady = 1'b0;
    unstable = 0;
    load(4, 32'h0000_0300);
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (OutValid && (OutData !== 32'h300 || OutLast !== 1'b0)) unstable++;
    end
    chk("bp_pops_held", 64'(pops), 64'd2);
    chk("bp_valid", 64'(OutValid), 64'd1);
    chk("bp_stable", 64'(unstable), 64'd0);
    OutReady = 1'b1;
    for (int i = 0; i < 4; i++) exp_w[i] = 32'h300 + 32'(i);
    run_done(4, 40);
    check_burst("bp", 4, 1, 1'b0);

    // Flush right after the second pop; remaining words plus new ones form a fresh burst.
    clear_stats();
    load(4, 32'h0000_0500);
    run_pops("fl", 2, 20);
    Flush = 1'b1;
    push_words[0] = 32'h600; push_words[1] = 32'h601; push_n = 2;
    @(negedge ReadClk);
    chk("fl_noread", 64'(FifoRead), 64'd0);
    @(posedge ReadClk);
    #1;
    Flush = 1'b0; push_n = 0;
    chk("fl_valid", 64'(OutValid), 64'd0);
    chk("fl_busy", 64'(Busy), 64'd0);
    chk("fl_bcount", 64'(BurstCount), 64'(exp_bc));
    clear_stats();
    exp_w[0] = 32'h502; exp_w[1] = 32'h503; exp_w[2] = 32'h600; exp_w[3] = 32'h601;
    run_done(4, 60);
    check_burst("fl_next", 4, 1, 1'b1);

    // Reset in BURST with the buffer full.
    clear_stats();
    OutReady = 1'b0;
    load(4, 32'h0000_0700);
    run_pops("rb", 2, 20);
    cycle();
    cycle();
    chk("rb_pops", 64'(pops), 64'd2);
    chk("rb_full_valid", 64'(OutValid), 64'd1);
    ReadReset = 1'b1;
    OutReady = 1'b1;
    @(negedge ReadClk);
    chk("rb_noread", 64'(FifoRead), 64'd0);
    @(posedge ReadClk);
    #1;
    exp_bc = '0;
    chk("rb_valid", 64'(OutValid), 64'd0);
    chk("rb_last", 64'(OutLast), 64'd0);
    chk("rb_data", 64'(OutData), 64'd0);
    chk("rb_busy", 64'(Busy), 64'd0);
    chk("rb_bcount", 64'(BurstCount), 64'(exp_bc));
    ReadReset = 1'b0;

    // Reset while a pop would otherwise be issued.
    clear_stats();
    load(4, 32'h0000_0800);
    run_pops("rp", 1, 20);
    ReadReset = 1'b1;
    @(negedge ReadClk);
    chk("rp_noread", 64'(FifoRead), 64'd0);
    @(posedge ReadClk);
    #1;
    ReadReset = 1'b0;
    chk("rp_busy", 64'(Busy), 64'd0);
    chk("rp_valid", 64'(OutValid), 64'd0);
    cycle();
    chk("rp_idle", 64'(Busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
